sc_env_rowgen: RTL

Upstream row source for the 8x8 environment shift-register bank of the road display. Generates each new top row (road walls plus pseudo-random obstacles) at a speed-selectable game tick. Drives the bank's shared load and clear strobes and its 8-bit input bus, so every tick scrolls the environment down one row. Also counts emitted rows for the score logic.

---
 rtl/sc_env_rowgen.sv | 136 +++++++++++++
 1 files changed

// File: rtl/sc_env_rowgen.sv
// rtl/sc_env_rowgen.sv - top-row generator for the 8x8 road environment shift-register bank
// Optional second obstacle per row: define SC_ENVROWGEN_DOUBLE_OBSTACLE_EN.
module sc_env_rowgen #(
    parameter int          TICK_DIV  = 25000000,
    parameter logic [7:0]  LFSR_SEED = 8'hA5,
    parameter int          GAP_ROWS  = 3
) (
    input  logic       SC_ENVROWGEN_CLOCK_50,
    input  logic       SC_ENVROWGEN_RESET_InLow,
    input  logic       SC_ENVROWGEN_start_InLow,
    input  logic [1:0] SC_ENVROWGEN_speed_InBUS,
    output logic       SC_ENVROWGEN_load_OutLow,
    output logic       SC_ENVROWGEN_clear_OutLow,
    output logic [7:0] SC_ENVROWGEN_data_OutBUS,
    output logic [7:0] SC_ENVROWGEN_rowcount_OutBUS
);

    localparam int CW = $clog2(TICK_DIV + 1);
    localparam int GW = (GAP_ROWS < 1) ? 1 : $clog2(GAP_ROWS + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_PAUSE
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   cnt;
    logic [GW-1:0]   gap;
    logic [7:0]      lfsr;
    logic [7:0]      lfsr_next;
    logic [31:0]     period;
    logic            active;
    logic            tick;
    logic            obstacle;
    logic [2:0]      pos_p;
    logic [7:0]      new_row;
`ifdef SC_ENVROWGEN_DOUBLE_OBSTACLE_EN
    logic [2:0]      pos_q;
`endif

    function automatic logic [2:0] mod6(input logic [2:0] v);
        return (v >= 3'd6) ? (v - 3'd6) : v;
    endfunction

    // Counting happens in RUN and on the PAUSE->RUN edge, so a pause of N
    // sampled-high cycles delays the next row by exactly N cycles.
    always_comb begin
        period    = 32'(TICK_DIV) >> SC_ENVROWGEN_speed_InBUS;
        active    = ((state == S_RUN) || (state == S_PAUSE)) && !SC_ENVROWGEN_start_InLow;
        tick      = active && (32'(cnt) >= (period - 32'd1));
        lfsr_next = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end

    always_comb begin
        obstacle = (gap == '0) && lfsr[7];
        pos_p    = mod6(lfsr[2:0]);
        new_row  = 8'h81;
        if (obstacle) begin
            new_row = 8'h81 | (8'd2 << pos_p);
`ifdef SC_ENVROWGEN_DOUBLE_OBSTACLE_EN
            pos_q = mod6(lfsr[5:3]);
            if (lfsr[6]) begin
                new_row = new_row | (8'd2 << pos_q);
            end
`endif
        end
`ifdef SC_ENVROWGEN_DOUBLE_OBSTACLE_EN
        else begin
            pos_q = mod6(lfsr[5:3]);
        end
`endif
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  state_next = SC_ENVROWGEN_start_InLow ? S_IDLE : S_CLEAR;
            S_CLEAR: state_next = S_RUN;
            S_RUN,
            S_PAUSE: state_next = SC_ENVROWGEN_start_InLow ? S_PAUSE : S_RUN;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge SC_ENVROWGEN_CLOCK_50 or negedge SC_ENVROWGEN_RESET_InLow) begin
        if (!SC_ENVROWGEN_RESET_InLow) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The clear cycle counts as the first tick cycle, so the first load lands
    // exactly one period after the clear strobe.
    always_ff @(posedge SC_ENVROWGEN_CLOCK_50 or negedge SC_ENVROWGEN_RESET_InLow) begin
        if (!SC_ENVROWGEN_RESET_InLow) begin
            cnt                          <= '0;
            gap                          <= '0;
            lfsr                         <= LFSR_SEED;
            SC_ENVROWGEN_load_OutLow     <= 1'b1;
            SC_ENVROWGEN_clear_OutLow    <= 1'b1;
            SC_ENVROWGEN_data_OutBUS     <= 8'h81;
            SC_ENVROWGEN_rowcount_OutBUS <= 8'd0;
        end else begin
            SC_ENVROWGEN_load_OutLow  <= !tick;
            SC_ENVROWGEN_clear_OutLow <= !(state_next == S_CLEAR);
            if (state == S_IDLE && !SC_ENVROWGEN_start_InLow) begin
                cnt                          <= '0;
                gap                          <= '0;
                lfsr                         <= LFSR_SEED;
                SC_ENVROWGEN_data_OutBUS     <= 8'h81;
                SC_ENVROWGEN_rowcount_OutBUS <= 8'd0;
            end else if (state == S_CLEAR) begin
                cnt <= CW'(1);
            end else if (active) begin
                if (tick) begin
                    cnt                          <= '0;
                    lfsr                         <= lfsr_next;
                    SC_ENVROWGEN_data_OutBUS     <= new_row;
                    SC_ENVROWGEN_rowcount_OutBUS <= SC_ENVROWGEN_rowcount_OutBUS + 8'd1;
                    if (obstacle) begin
                        gap <= GW'(GAP_ROWS);
                    end else if (gap != '0) begin
                        gap <= gap - GW'(1);
                    end
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

endmodule
